// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    ERROR     = 2'd2
  } state_t;

  localparam logic [4:0]  X0              = 5'd0;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: an EX-stage load whose destination is read by ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       lu
);

  always_comb begin
    lu = ex_mem_read && (ex_rd != X0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline enable/stall/flush controller with data-bus wait FSM and perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pipe_en,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu, run_en, redirect_apply, lu_apply, bubble_apply, stall_inc;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu          (lu)
  );

  always_comb begin
    state_d = state_q;
    run_en  = 1'b0;
    unique case (state_q)
      RUN: begin
        run_en = !(mem_req && !dmem_ready);
        if (!run_en) state_d = DMEM_WAIT;
      end
      DMEM_WAIT: begin
        // A ready arriving on the final allowed wait cycle still resumes.
        run_en = dmem_ready;
        if (dmem_ready)                state_d = RUN;
        else if (wait_cnt == WAIT_LAST) state_d = ERROR;
      end
      ERROR:   run_en = 1'b0;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pipe_en        = reset && run_en;
    redirect_apply = pipe_en && ex_redirect;
    lu_apply       = pipe_en && !ex_redirect && lu;
    bubble_apply   = pipe_en && !ex_redirect && !lu && !imem_ready;
    pc_hold        = lu_apply || bubble_apply;
    ifid_hold      = lu_apply;
    ifid_flush     = redirect_apply || bubble_apply;
    idex_stall     = lu_apply;
    idex_flush     = redirect_apply;
    stall_inc      = lu_apply || bubble_apply || (!run_en && (state_q != ERROR));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN)            wait_cnt <= '0;
      else if (state_q == DMEM_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (state_d == ERROR)          bus_err  <= 1'b1;
      if (stall_inc)                 stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_apply)            flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: per-cycle expected outputs queued at drive, checked at negedge.
module tb_pipeline_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0, ex_redirect = 1'b0;
  logic          mem_req = 1'b0, dmem_ready = 1'b1, imem_ready = 1'b1;
  logic          pipe_en, pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush, bus_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state;

  pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pipe_en(pipe_en), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .bus_err(bus_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, redir, mreq, dready, iready;
  } stim_t;

  typedef struct packed {
    logic          pipe_en, pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush, bus_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    state;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_state = 0;
  int            m_wait = 0;
  logic [CW-1:0] m_stall = '0, m_flush = '0;
  logic          m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s        = '0;
    s.rst    = 1'b1;
    s.dready = 1'b1;
    s.iready = 1'b1;
    return s;
  endfunction

  // One clock cycle: drive, predict, compare at negedge, advance the model at posedge.
  task automatic cyc(input stim_t s);
    exp_t e, g;
    logic lu, en, red, stl, bub;
    #1;
    reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    ex_rd = s.rd; ex_mem_read = s.mr; ex_redirect = s.redir; mem_req = s.mreq;
    dmem_ready = s.dready; imem_ready = s.iready;
    if (!s.rst) begin
      m_state = 0; m_wait = 0; m_stall = '0; m_flush = '0; m_err = 1'b0;
    end
    lu = s.mr && (s.rd != 5'd0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    case (m_state)
      0:       en = !(s.mreq && !s.dready);
      1:       en = s.dready;
      default: en = 1'b0;
    endcase
    red = s.rst && en && s.redir;
    stl = s.rst && en && !s.redir && lu;
    bub = s.rst && en && !s.redir && !lu && !s.iready;
    e.pipe_en    = s.rst && en;
    e.pc_hold    = stl || bub;
    e.ifid_hold  = stl;
    e.ifid_flush = red || bub;
    e.idex_stall = stl;
    e.idex_flush = red;
    e.bus_err    = m_err;
    e.stall_cnt  = m_stall;
    e.flush_cnt  = m_flush;
    e.state      = 2'(m_state);
    sb.push_back(e);
    @(negedge clk);
    g = {pipe_en, pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush, bus_err,
         stall_cnt, flush_cnt, state};
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check("pipe_en",    32'(g.pipe_en),    32'(e.pipe_en));
      check("pc_hold",    32'(g.pc_hold),    32'(e.pc_hold));
      check("ifid_hold",  32'(g.ifid_hold),  32'(e.ifid_hold));
      check("ifid_flush", 32'(g.ifid_flush), 32'(e.ifid_flush));
      check("idex_stall", 32'(g.idex_stall), 32'(e.idex_stall));
      check("idex_flush", 32'(g.idex_flush), 32'(e.idex_flush));
      check("bus_err",    32'(g.bus_err),    32'(e.bus_err));
      check("stall_cnt",  32'(g.stall_cnt),  32'(e.stall_cnt));
      check("flush_cnt",  32'(g.flush_cnt),  32'(e.flush_cnt));
      check("state",      32'(g.state),      32'(e.state));
    end
    @(posedge clk);
    if (s.rst) begin
      if (stl || bub || (!en && m_state != 2)) m_stall = m_stall + 1'b1;
      if (red) m_flush = m_flush + 1'b1;
      case (m_state)
        0: begin
          m_wait = 0;
          if (s.mreq && !s.dready) m_state = 1;
        end
        1: begin
          if (s.dready) m_state = 0;
          else if (m_wait == int'(TO) - 1) begin m_state = 2; m_err = 1'b1; end
          m_wait++;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    stim_t s;
    @(posedge clk);
    s = idle(); s.rst = 1'b0;
    repeat (2) cyc(s);
    repeat (2) cyc(idle());

    // Load-use on rs2
    s = idle(); s.mr = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
    cyc(s);
    cyc(idle());
    s.rd = 5'd0; s.rs2 = 5'd0; cyc(s);
    s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b0; cyc(s);
    s = idle(); s.mr = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1; cyc(s);

    // Redirect overriding load-use
    s = idle(); s.mr = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1; s.redir = 1'b1;
    cyc(s);

    // Three-cycle data-memory wait, then resume
    s = idle(); s.mreq = 1'b1; s.dready = 1'b0;
    repeat (3) cyc(s);
    s.dready = 1'b1; cyc(s);
    cyc(idle());

    // Two-cycle instruction-fetch bubble
    s = idle(); s.iready = 1'b0;
    repeat (2) cyc(s);

    // Redirect during freeze is not applied, then applied once enabled
    s = idle(); s.mreq = 1'b1; s.dready = 1'b0; s.redir = 1'b1;
    repeat (2) cyc(s);
    s.dready = 1'b1; cyc(s);

    // Ready arriving on the last allowed wait cycle wins
    s = idle(); s.mreq = 1'b1; s.dready = 1'b0;
    repeat (TO) cyc(s);
    s.dready = 1'b1; cyc(s);
    cyc(idle());

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      s        = idle();
      s.rs1    = 5'($urandom_range(0, 3));
      s.rs2    = 5'($urandom_range(0, 3));
      s.rd     = 5'($urandom_range(0, 3));
      s.u1     = 1'($urandom_range(0, 1));
      s.u2     = 1'($urandom_range(0, 1));
      s.mr     = 1'($urandom_range(0, 1));
      s.redir  = ($urandom_range(0, 4) == 0);
      s.mreq   = ($urandom_range(0, 2) == 0);
      s.dready = ($urandom_range(0, 2) != 0);
      s.iready = ($urandom_range(0, 3) != 0);
      cyc(s);
    end
    s = idle(); s.rst = 1'b0; cyc(s);
    cyc(idle());

    // Timeout into ERROR, held, then cleared by reset
    s = idle(); s.mreq = 1'b1; s.dready = 1'b0;
    repeat (TO + 4) cyc(s);
    s = idle(); cyc(s);
    s.rst = 1'b0; cyc(s);
    repeat (2) cyc(idle());

    // Reset asserted mid-wait
    s = idle(); s.mreq = 1'b1; s.dready = 1'b0;
    repeat (2) cyc(s);
    s.rst = 1'b0; cyc(s);
    cyc(idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It produces the per-cycle enable, stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken branches/jumps, and instruction- and data-memory wait states, and freezes the pipeline on a data-bus timeout. It sits beside the datapath, takes hazard sources from ID, EX and MEM, and drives the `stall` and `branch` inputs of the ID/EX register directly.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of consecutive DMEM_WAIT cycles before the block declares a bus error.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads that source.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_redirect` in 1: a taken branch, JAL or JALR is resolved in EX this cycle.
- `mem_req` in 1: the MEM-stage instruction accesses data memory.
- `dmem_ready` in 1: data-memory access completes this cycle.
- `imem_ready` in 1: instruction fetch is valid this cycle.
- `pipe_en` out 1: global clock-enable for all pipeline registers and the PC.
- `pc_hold`, `ifid_hold` out 1: hold the PC and IF/ID contents.
- `ifid_flush` out 1: load a NOP into IF/ID.
- `idex_stall` out 1: inject a bubble into ID/EX (load-use case).
- `idex_flush` out 1: kill the instruction entering ID/EX (redirect case).
- `bus_err` out 1: sticky error flag.
- `stall_cnt`, `flush_cnt` out CNT_W: performance counters.
- `state` out 2: current FSM state.

## Operation
- FSM states: RUN=0, DMEM_WAIT=1, ERROR=2.
  - RUN → DMEM_WAIT when `mem_req & !dmem_ready`.
  - DMEM_WAIT → RUN on `dmem_ready`.
  - DMEM_WAIT → ERROR when the wait counter reaches TIMEOUT with `dmem_ready` still low.
  - ERROR is terminal until reset.
- `pipe_en`:
  - 0 in DMEM_WAIT, in ERROR, and in RUN while `mem_req & !dmem_ready`.
  - 1 otherwise.
  - The freeze is therefore combinational on the first wait cycle.
- Every stall and flush output is gated by `pipe_en`; none is asserted while the pipeline is frozen.
- Load-use hazard (`lu`): `ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
- Priority when `pipe_en`=1:
  1. `ex_redirect`: `ifid_flush`=1, `idex_flush`=1. Overrides `lu` and imem wait; `pc_hold`=0 so the PC loads the target.
  2. `lu`: `pc_hold`=1, `ifid_hold`=1, `idex_stall`=1.
  3. `!imem_ready`: `pc_hold`=1, `ifid_flush`=1 (IF/ID receives a bubble; downstream stages advance).
- Counters:
  - `stall_cnt` increments on each cycle with `lu` or an imem bubble applied, or with `pipe_en`=0 outside ERROR.
  - `flush_cnt` increments on each cycle a redirect is applied.
  - Both wrap modulo 2^CNT_W.
- The wait counter clears in RUN and increments each DMEM_WAIT cycle. Its width is $clog2(TIMEOUT+1).
- `bus_err` sets on entry to ERROR and is cleared only by reset.

## Timing
- Control outputs are combinational from the inputs and `state`, valid in the same cycle. State, counters and `bus_err` update on the rising `clk` edge.
- Load-use costs exactly 1 bubble. A redirect costs 2 killed slots (IF/ID and ID/EX) in a single cycle.
- Data-memory wait:
  - Freeze lasts N cycles for N low cycles of `dmem_ready`.
  - Resume happens on the cycle `dmem_ready` rises. `pipe_en`=1 in that cycle.
- A `ex_redirect` asserted during a freeze is held by the frozen EX stage and applied on the first enabled cycle.
- Timeout: ERROR is entered on the edge after the (TIMEOUT)th DMEM_WAIT cycle without ready. A `dmem_ready` arriving in that same cycle wins, and the FSM returns to RUN.
- Reset values:
  - Registered: `state`=RUN, `stall_cnt`=0, `flush_cnt`=0, wait counter=0, `bus_err`=0.
  - While `reset` is low, all combinational outputs are forced to 0, including `pipe_en`.
- Reset asserted mid-wait or in ERROR returns the block to RUN immediately (asynchronous).

## Structure
- Package `pipe_ctrl_pkg` holds the state encoding (RUN/DMEM_WAIT/ERROR), the X0 constant, and the default TIMEOUT.
- Sub-module `hazard_detect` is purely combinational. It computes `lu` from the ID/EX fields and is reusable by the forwarding unit.
- The FSM, counters and output gating live in the top level.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → 1 cycle with `pc_hold`/`ifid_hold`/`idex_stall`=1; `stall_cnt` goes 0→1.
- Same as above but `ex_rd`=0, or `id_use_rs2`=0 → no stall.
- `ex_redirect` together with `lu` → `ifid_flush`=`idex_flush`=1, `idex_stall`=0, `pc_hold`=0; `flush_cnt`=1.
- `mem_req`=1 with `dmem_ready` low for 3 cycles → `pipe_en`=0 for 3 cycles, `state`=1 for cycles 2-3, RUN after ready; `stall_cnt`=3.
- TIMEOUT=4 with `dmem_ready` held low → `state`=2 and `bus_err`=1 after the 4th wait cycle; `pipe_en` stays 0. Pulsing reset low → `state`=0, counters 0.
- `imem_ready`=0 for 2 cycles with no hazards → `ifid_flush`=1 and `pc_hold`=1 for 2 cycles, `idex_stall`=0.
